// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//  - FSM state encodings (FETCH, WAIT, HOLD, HALT)
//  - Opcode field width and the HLT opcode constant
//  - Helper that classifies an opcode as HLT
package instr_fetch_unit_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_HLT = 3'b111;

  typedef enum logic [1:0] {
    FSM_FETCH = 2'd0,
    FSM_WAIT  = 2'd1,
    FSM_HOLD  = 2'd2,
    FSM_HALT  = 2'd3
  } fsm_state_t;

  // True when the opcode stops the core.
  function automatic logic is_halt_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_HLT);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register for the fetch unit.
// Ports:
//  clk          in   rising-edge clock
//  rst_n        in   asynchronous active-low reset (loads RESET_PC)
//  i_load       in   load i_load_addr (branch taken); wins over i_inc
//  i_inc        in   advance PC by one, modulo 2^ADDR_W
//  i_load_addr  in   branch target
//  o_pc         out  current PC
module instr_fetch_unit_pc_reg #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_load_addr,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Natural-width add wraps all-ones back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/sequence stage feeding the 3x8 opcode decoder.
// Holds PC and IR, fetches one instruction at a time over a req/ack port,
// holds it until the execute stage finishes, then advances or branches.
// Optional feature: define FETCH_TMO_EN to halt with fetch_err after
// TMO_CYC cycles in WAIT without an ack; otherwise WAIT waits forever.
// Ports:
//  clk          in   rising-edge clock
//  rst_n        in   asynchronous active-low reset
//  mem_req      out  fetch request, held until mem_ack
//  mem_addr     out  fetch address (= PC)
//  mem_rdata    in   instruction data, sampled with mem_ack
//  mem_ack      in   fetch complete (single-cycle pulse)
//  opcode       out  IR opcode field
//  operand      out  IR operand field
//  instr_valid  out  opcode/operand hold a live instruction
//  exec_done    in   execute stage finished the current instruction
//  branch_en    in   take branch (sampled with exec_done)
//  branch_addr  in   branch target
//  halted       out  core stopped (HLT opcode or timeout)
//  fetch_err    out  ack timeout occurred
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TMO_CYC  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic [OPC_W-1:0]   opcode,
  output logic [INSTR_W-4:0] operand,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               halted,
  output logic               fetch_err
);

  fsm_state_t         r_state;
  logic [INSTR_W-1:0] r_ir;
  logic               r_mem_req;
  logic               r_instr_valid;
  logic               r_halted;

  logic [ADDR_W-1:0]  w_pc;
  logic               w_is_hlt;
  logic               w_exec_take;
  logic               w_pc_load;
  logic               w_pc_inc;

`ifdef FETCH_TMO_EN
  localparam int unsigned TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_fetch_err;
  logic               w_tmo_hit;

  // Counter holds the number of ack-less WAIT cycles already elapsed.
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TMO_CYC - 1));
`else
  logic               w_unused_tmo;

  assign w_unused_tmo = (TMO_CYC == 0);
`endif

  assign opcode   = r_ir[INSTR_W-1 -: OPC_W];
  assign operand  = r_ir[INSTR_W-4:0];
  assign w_is_hlt = is_halt_op(opcode);

  // HLT in HOLD overrides exec_done, so the PC never moves past a HLT.
  assign w_exec_take = (r_state == FSM_HOLD) && !w_is_hlt && exec_done;
  assign w_pc_load   = w_exec_take && branch_en;
  assign w_pc_inc    = w_exec_take && !branch_en;

  instr_fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_pc_load),
    .i_inc       (w_pc_inc),
    .i_load_addr (branch_addr),
    .o_pc        (w_pc)
  );

  // Fetch sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FSM_FETCH;
      r_ir          <= '0;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
`ifdef FETCH_TMO_EN
      r_tmo_cnt     <= '0;
      r_fetch_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        FSM_FETCH: begin
          r_mem_req <= 1'b1;
          r_state   <= FSM_WAIT;
`ifdef FETCH_TMO_EN
          r_tmo_cnt <= '0;
`endif
        end

        // An ack in the first WAIT cycle is the 2-cycle minimum latency.
        FSM_WAIT: begin
          if (mem_ack) begin
            r_ir          <= mem_rdata;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= FSM_HOLD;
          end
`ifdef FETCH_TMO_EN
          else if (w_tmo_hit) begin
            r_mem_req   <= 1'b0;
            r_halted    <= 1'b1;
            r_fetch_err <= 1'b1;
            r_state     <= FSM_HALT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
`endif
        end

        FSM_HOLD: begin
          if (w_is_hlt) begin
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b1;
            r_state       <= FSM_HALT;
          end else if (exec_done) begin
            r_instr_valid <= 1'b0;
            r_state       <= FSM_FETCH;
          end
        end

        // Absorbing; only reset leaves.
        FSM_HALT: begin
          r_mem_req <= 1'b0;
        end

        default: begin
          r_state <= FSM_FETCH;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = w_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;

`ifdef FETCH_TMO_EN
  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule
